// File: rtl/shared_resource_responder.sv
// rtl/shared_resource_responder.sv - two-initiator arbitrated sequential 16x16 shift-add multiplier
// Define SHARED_RESP_ROUND_ROBIN_EN for round-robin arbitration; otherwise pipeline 1 has fixed priority.
module shared_resource_responder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic                  flush_1,
  input  logic                  flush_2,
  output logic                  grant_1,
  output logic                  grant_2,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_id
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(HW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [HW-1:0]         b_reg;
  logic [DATA_WIDTH-1:0] acc;
  logic [CW-1:0]         cnt;
  logic                  owner;

  logic                  eff_1, eff_2, pick_2, owner_flush, last_step;
  logic [DATA_WIDTH-1:0] sum;

  assign eff_1       = req_1 & ~flush_1;
  assign eff_2       = req_2 & ~flush_2;
  assign owner_flush = owner ? flush_2 : flush_1;
  assign sum         = acc + (b_reg[0] ? a_reg : '0);
  assign last_step   = (cnt == CW'(HW - 1));

`ifdef SHARED_RESP_ROUND_ROBIN_EN
  // prio_2 set means pipeline 1 was served last, so pipeline 2 wins a tie
  logic prio_2;
  assign pick_2 = eff_2 & (~eff_1 | prio_2);
`else
  assign pick_2 = eff_2 & ~eff_1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      grant_1    <= 1'b0;
      grant_2    <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
`ifdef SHARED_RESP_ROUND_ROBIN_EN
      prio_2     <= 1'b0;
`endif
    end else begin
      grant_1    <= 1'b0;
      grant_2    <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (eff_1 | eff_2) begin
            owner   <= pick_2;
            grant_1 <= ~pick_2;
            grant_2 <= pick_2;
            a_reg   <= {{HW{1'b0}}, (pick_2 ? data_2[HW-1:0] : data_1[HW-1:0])};
            b_reg   <= pick_2 ? data_2[DATA_WIDTH-1:HW] : data_1[DATA_WIDTH-1:HW];
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= BUSY;
`ifdef SHARED_RESP_ROUND_ROBIN_EN
            prio_2  <= ~pick_2;
`endif
          end
        end
        BUSY: begin
          if (owner_flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc   <= sum;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + CW'(1);
            if (last_step) begin
              resp_valid <= 1'b1;
              resp_data  <= sum;
              resp_id    <= owner;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
